ucsbece154b_gshare_bpred: RTL and testbench
===========================================

# ucsbece154b_gshare_bpred

Gshare branch predictor serving the fetch stage of the five-stage RISC-V pipeline. It receives the fetch PC and returns a predicted-taken flag and target in the same cycle. It accepts resolved-branch updates from the execute stage: BTB fill, PHT counter training and GHR recovery. It is the responder to the predictor-control signals the datapath generates in EX and F.

## Interface
- NUM_BTB_ENTRIES, 32, BTB depth; power of two; NUM_IDX_BITS = $clog2(NUM_BTB_ENTRIES)
- NUM_GHR_BITS, 5, GHR width; PHT depth = 2**NUM_GHR_BITS
- TAG_BITS, derived, 30 - NUM_IDX_BITS (PC bits [31:NUM_IDX_BITS+2])

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_i  in  1  reset; one clock; reset is asynchronous and active-high
- pc_i  in  32  fetch-stage PC
- BranchTaken_o  out  1  predict redirect to BTBtarget_o this cycle
- BTBtarget_o  out  32  predicted target
- PHTreadaddress_o  out  NUM_GHR_BITS  PHT index used for this prediction; the datapath pipelines it to EX
- BTB_we  in  1  write the BTB entry
- BTBwriteaddress_i  in  NUM_IDX_BITS  BTB index, PC_E[NUM_IDX_BITS+1:2]
- BTBwritetag_i  in  TAG_BITS  tag, PC_E[31:NUM_IDX_BITS+2]
- BTBwritedata_i  in  32  resolved target
- BTBwritejump_i  in  1  entry is jal/jalr (always taken)
- PHTwe_i  in  1  train the PHT counter
- PHTwriteaddress_i  in  NUM_GHR_BITS  counter index (the pipelined PHTreadaddress_o)
- PHTincrement_i  in  1  1 = resolved taken, 0 = resolved not-taken
- GHRwe_i  in  1  fetched instruction is a conditional branch; shift the history
- GHRreset_i  in  1  EX misprediction; clear the history

## Operation
- State:
  - BTB: valid[N], tag[N], target[N], jump[N]
  - PHT: 2**NUM_GHR_BITS two-bit saturating counters
  - GHR: NUM_GHR_BITS-bit shift register
- Read path is purely combinational from pc_i and the current state:
  - idx = pc_i[NUM_IDX_BITS+1:2]
  - hit = valid[idx] && tag[idx] == pc_i[31:NUM_IDX_BITS+2]
  - PHTreadaddress_o = pc_i[NUM_GHR_BITS+1:2] ^ GHR
  - BranchTaken_o = hit && (jump[idx] || PHT[PHTreadaddress_o][1])
  - BTBtarget_o = target[idx], regardless of hit
- BTB write: when BTB_we, entry BTBwriteaddress_i gets valid=1, tag, target and jump from the inputs. Overwrite is unconditional and there is no replacement policy.
- PHT write: when PHTwe_i, counter at PHTwriteaddress_i is updated.
  - PHTincrement_i = 1: increment, saturating at 2'b11.
  - PHTincrement_i = 0: decrement, saturating at 2'b00.
- GHR, in priority order:
  - GHRreset_i: GHR <= 0.
  - Else GHRwe_i: GHR <= {GHR[NUM_GHR_BITS-2:0], BranchTaken_o}. The speculative prediction is shifted in at the LSB.
  - Else hold.
- BTB, PHT and GHR writes are independent. All three may occur in the same cycle.

## Timing
- Prediction latency is 0 cycles (combinational) and is valid in the same cycle as pc_i.
- Writes take effect at the next rising edge. A same-cycle read of the written location returns the old value; there is no write-to-read bypass.
- GHRreset_i and GHRwe_i in the same cycle: the reset wins and GHR = 0. The shifted bit is discarded.
- Asynchronous reset values:
  - all valid = 0, all tag, target and jump = 0
  - all PHT counters = 2'b01 (weakly not-taken)
  - GHR = 0
- Output values during reset: BranchTaken_o = 0, BTBtarget_o = 0, PHTreadaddress_o = pc_i[NUM_GHR_BITS+1:2].
- Reset asserted mid-operation clears state immediately, without waiting for clk. Writes presented in the same cycle as reset are lost.
- Index wrap: BTB and PHT indices are truncated bit fields. PCs differing only above the index are distinguished by tag in the BTB and alias in the PHT.

## Test plan
- Reset, then pc_i = 0x0000_0010:
  - BranchTaken_o = 0, BTBtarget_o = 0, PHTreadaddress_o = 5'b00100.
- BTB_we, addr 4, tag 0, data 0x0000_0040, jump = 1; next cycle pc_i = 0x10:
  - BranchTaken_o = 1, BTBtarget_o = 0x40.
  - pc_i = 0x90 (same idx, tag 1) gives BranchTaken_o = 0.
- Conditional entry at idx 4 (jump = 0), GHR = 0:
  - Before training: BranchTaken_o = 0.
  - One PHTwe_i with increment at addr 4: counter = 2'b10, then BranchTaken_o = 1 at pc 0x10.
  - Three more increments: counter stays at 2'b11.
  - Four decrements: counter reaches 2'b00 and stays there.
- GHR shift: hit-taken branch at pc_i with GHRwe_i held for 3 cycles gives GHR = 5'b00111. PHTreadaddress_o at pc 0x10 then = 5'b00011.
- GHRwe_i and GHRreset_i asserted together gives GHR = 0 next cycle.
- Same-cycle write and read of BTB idx 4 returns the old target; the new target is visible the following cycle.
- Reset asserted between clock edges clears BranchTaken_o before the next edge.

Source files
------------

// File: rtl/ucsbece154b_gshare_bpred.sv
// Gshare branch predictor for the fetch stage.
// The fetch PC indexes a direct-mapped BTB. The fetch PC is also XORed with the
// global history, and that result indexes a table of 2-bit counters. The
// prediction is combinational. BTB, PHT and GHR updates arrive from the
// execute stage and take effect on the next rising edge.
module ucsbece154b_gshare_bpred #(
    parameter  int NUM_BTB_ENTRIES = 32,
    parameter  int NUM_GHR_BITS    = 5,
    localparam int NUM_IDX_BITS    = $clog2(NUM_BTB_ENTRIES),
    localparam int TAG_BITS        = 30 - NUM_IDX_BITS
) (
    input  logic                    clk,
    input  logic                    reset_i,
    input  logic [31:0]             pc_i,
    output logic                    BranchTaken_o,
    output logic [31:0]             BTBtarget_o,
    output logic [NUM_GHR_BITS-1:0] PHTreadaddress_o,
    input  logic                    BTB_we,
    input  logic [NUM_IDX_BITS-1:0] BTBwriteaddress_i,
    input  logic [TAG_BITS-1:0]     BTBwritetag_i,
    input  logic [31:0]             BTBwritedata_i,
    input  logic                    BTBwritejump_i,
    input  logic                    PHTwe_i,
    input  logic [NUM_GHR_BITS-1:0] PHTwriteaddress_i,
    input  logic                    PHTincrement_i,
    input  logic                    GHRwe_i,
    input  logic                    GHRreset_i
);

    localparam int PHT_DEPTH = 2 ** NUM_GHR_BITS;

    // Two-bit counter encodings that the reset and saturation logic use.
    localparam logic [1:0] CNT_MIN       = 2'b00;
    localparam logic [1:0] CNT_WEAK_NT   = 2'b01;
    localparam logic [1:0] CNT_MAX       = 2'b11;

    // Predictor state
    logic                    btb_valid  [NUM_BTB_ENTRIES];
    logic [TAG_BITS-1:0]     btb_tag    [NUM_BTB_ENTRIES];
    logic [31:0]             btb_target [NUM_BTB_ENTRIES];
    logic                    btb_jump   [NUM_BTB_ENTRIES];
    logic [1:0]              pht        [PHT_DEPTH];
    logic [NUM_GHR_BITS-1:0] ghr;

    // Read-path signals
    logic [NUM_IDX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]     pc_tag;
    logic [NUM_GHR_BITS-1:0] pht_idx;
    logic                    hit;

    // Instructions are word aligned, so the byte-offset bits carry no information.
    wire unused_pc_bits = ^pc_i[1:0];

    // Combinational lookup: BTB hit check and the gshare counter index
    always_comb begin
        idx     = pc_i[NUM_IDX_BITS+1:2];
        pc_tag  = pc_i[31:NUM_IDX_BITS+2];
        pht_idx = pc_i[NUM_GHR_BITS+1:2] ^ ghr;
        hit     = btb_valid[idx] && (btb_tag[idx] == pc_tag);
    end

    assign PHTreadaddress_o = pht_idx;
    assign BTBtarget_o      = btb_target[idx];
    assign BranchTaken_o    = hit && (btb_jump[idx] || pht[pht_idx][1]);

    // BTB fill: unconditional overwrite of the addressed entry
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            // NOTE: the whole table is cleared on reset. The predictor must not hit on a stale
            // entry after reset, so this array cannot be mapped to a RAM macro.
            for (int i = 0; i < NUM_BTB_ENTRIES; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
                btb_jump[i]   <= 1'b0;
            end
        end else if (BTB_we) begin
            // NOTE: non-blocking updates mean a same-cycle lookup still sees the old entry.
            btb_valid[BTBwriteaddress_i]  <= 1'b1;
            btb_tag[BTBwriteaddress_i]    <= BTBwritetag_i;
            btb_target[BTBwriteaddress_i] <= BTBwritedata_i;
            btb_jump[BTBwriteaddress_i]   <= BTBwritejump_i;
        end
    end

    // PHT training: saturating increment/decrement of one 2-bit counter
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < PHT_DEPTH; i++) begin
                pht[i] <= CNT_WEAK_NT;
            end
        end else if (PHTwe_i) begin
            if (PHTincrement_i) begin
                if (pht[PHTwriteaddress_i] != CNT_MAX) begin
                    pht[PHTwriteaddress_i] <= pht[PHTwriteaddress_i] + 2'd1;
                end
            end else begin
                if (pht[PHTwriteaddress_i] != CNT_MIN) begin
                    pht[PHTwriteaddress_i] <= pht[PHTwriteaddress_i] - 2'd1;
                end
            end
        end
    end

    // Global history: a misprediction clear wins over a speculative shift
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            ghr <= '0;
        end else if (GHRreset_i) begin
            ghr <= '0;
        end else if (GHRwe_i) begin
            ghr <= {ghr[NUM_GHR_BITS-2:0], BranchTaken_o};
        end
    end

endmodule

// File: tb/tb_ucsbece154b_gshare_bpred.sv
// Self-checking bench for ucsbece154b_gshare_bpred.
// Each table-driven vector presents pc_i and the write controls at a falling
// edge. The bench checks the outputs 1 ns later, before any write commits, and
// then lets the rising edge apply the writes. Hand-written sequences follow
// for reset between clock edges and for writes lost during reset.
module tb_ucsbece154b_gshare_bpred;

    logic        clk;
    logic        reset_i;
    logic [31:0] pc_i;
    logic        BranchTaken_o;
    logic [31:0] BTBtarget_o;
    logic [4:0]  PHTreadaddress_o;
    logic        BTB_we;
    logic [4:0]  BTBwriteaddress_i;
    logic [24:0] BTBwritetag_i;
    logic [31:0] BTBwritedata_i;
    logic        BTBwritejump_i;
    logic        PHTwe_i;
    logic [4:0]  PHTwriteaddress_i;
    logic        PHTincrement_i;
    logic        GHRwe_i;
    logic        GHRreset_i;

    int checks;
    int errors;

    ucsbece154b_gshare_bpred #(.NUM_BTB_ENTRIES(32), .NUM_GHR_BITS(5)) dut (
        .clk               (clk),
        .reset_i           (reset_i),
        .pc_i              (pc_i),
        .BranchTaken_o     (BranchTaken_o),
        .BTBtarget_o       (BTBtarget_o),
        .PHTreadaddress_o  (PHTreadaddress_o),
        .BTB_we            (BTB_we),
        .BTBwriteaddress_i (BTBwriteaddress_i),
        .BTBwritetag_i     (BTBwritetag_i),
        .BTBwritedata_i    (BTBwritedata_i),
        .BTBwritejump_i    (BTBwritejump_i),
        .PHTwe_i           (PHTwe_i),
        .PHTwriteaddress_i (PHTwriteaddress_i),
        .PHTincrement_i    (PHTincrement_i),
        .GHRwe_i           (GHRwe_i),
        .GHRreset_i        (GHRreset_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        btb_we;
        logic [4:0]  btb_addr;
        logic [24:0] btb_tag;
        logic [31:0] btb_data;
        logic        btb_jump;
        logic        pht_we;
        logic [4:0]  pht_addr;
        logic        pht_inc;
        logic        ghr_we;
        logic        ghr_reset;
        logic [31:0] pc;
        logic        exp_taken;
        logic [31:0] exp_target;
        logic [4:0]  exp_pht;
    } vec_t;

    localparam int NUM_VECS = 26;
    vec_t vecs [NUM_VECS];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic idle_inputs();
        BTB_we = 1'b0; BTBwriteaddress_i = '0; BTBwritetag_i = '0; BTBwritedata_i = '0;
        BTBwritejump_i = 1'b0; PHTwe_i = 1'b0; PHTwriteaddress_i = '0; PHTincrement_i = 1'b0;
        GHRwe_i = 1'b0; GHRreset_i = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v, input int n);
        @(negedge clk);
        BTB_we = v.btb_we; BTBwriteaddress_i = v.btb_addr; BTBwritetag_i = v.btb_tag;
        BTBwritedata_i = v.btb_data; BTBwritejump_i = v.btb_jump;
        PHTwe_i = v.pht_we; PHTwriteaddress_i = v.pht_addr; PHTincrement_i = v.pht_inc;
        GHRwe_i = v.ghr_we; GHRreset_i = v.ghr_reset; pc_i = v.pc;
        #1;
        check($sformatf("v%0d taken", n), {31'd0, BranchTaken_o}, {31'd0, v.exp_taken});
        check($sformatf("v%0d target", n), BTBtarget_o, v.exp_target);
        check($sformatf("v%0d phtaddr", n), {27'd0, PHTreadaddress_o}, {27'd0, v.exp_pht});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        // btb: we addr tag data jump | pht: we addr inc | ghr: we rst | pc | exp: taken target pht
        // Reset state, then a jump entry at idx 4 (written and read in the same cycle).
        vecs[0]  = '{1'b0, 5'd0, 25'd0, 32'h0,   1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h10, 1'b0, 32'h0,  5'd4};
        vecs[1]  = '{1'b1, 5'd4, 25'd0, 32'h40,  1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h10, 1'b0, 32'h0,  5'd4};
        vecs[2]  = '{1'b0, 5'd0, 25'd0, 32'h0,   1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 32'h40, 5'd4};
        // Same index with tag 1 misses, but the target still reads out.
        vecs[3]  = '{1'b0, 5'd0, 25'd0, 32'h0,   1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h90, 1'b0, 32'h40, 5'd4};
        // Replace with a conditional entry, then train counter 4 up, then down.
        vecs[4]  = '{1'b1, 5'd4, 25'd0, 32'h80,  1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 32'h40, 5'd4};
        vecs[5]  = '{1'b0, 5'd0, 25'd0, 32'h0,   1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 32'h10, 1'b0, 32'h80, 5'd4};
        vecs[6]  = '{1'b0, 5'd0, 25'd0, 32'h0,   1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 32'h80, 5'd4};
        vecs[7]  = '{1'b0, 5'd0, 25'd0, 32'h0,   1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 32'h80, 5'd4};
        vecs[8]  = '{1'b0, 5'd0, 25'd0, 32'h0,   1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 32'h80, 5'd4};
        vecs[9]  = '{1'b0, 5'd0, 25'd0, 32'h0,   1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 32'h80, 5'd4};
        vecs[10] = '{1'b0, 5'd0, 25'd0, 32'h0,   1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 32'h80, 5'd4};
        vecs[11] = '{1'b0, 5'd0, 25'd0, 32'h0,   1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 32'h10, 1'b0, 32'h80, 5'd4};
        vecs[12] = '{1'b0, 5'd0, 25'd0, 32'h0,   1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 32'h10, 1'b0, 32'h80, 5'd4};
        vecs[13] = '{1'b0, 5'd0, 25'd0, 32'h0,   1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 32'h10, 1'b0, 32'h80, 5'd4};
        vecs[14] = '{1'b0, 5'd0, 25'd0, 32'h0,   1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 32'h10, 1'b0, 32'h80, 5'd4};
        vecs[15] = '{1'b0, 5'd0, 25'd0, 32'h0,   1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 32'h80, 5'd4};
        // Jump entry again, so that three history shifts all insert a 1.
        vecs[16] = '{1'b1, 5'd4, 25'd0, 32'h100, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 32'h80, 5'd4};
        vecs[17] = '{1'b0, 5'd0, 25'd0, 32'h0,   1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 32'h100, 5'd4};
        vecs[18] = '{1'b0, 5'd0, 25'd0, 32'h0,   1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 32'h100, 5'd5};
        vecs[19] = '{1'b0, 5'd0, 25'd0, 32'h0,   1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 32'h100, 5'd7};
        vecs[20] = '{1'b0, 5'd0, 25'd0, 32'h0,   1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 32'h100, 5'd3};
        // Shift and clear in the same cycle: the clear wins.
        vecs[21] = '{1'b0, 5'd0, 25'd0, 32'h0,   1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h100, 5'd3};
        vecs[22] = '{1'b0, 5'd0, 25'd0, 32'h0,   1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 32'h100, 5'd4};
        // A not-taken prediction (miss at idx 8) shifts in a 0, then a taken one shifts in a 1.
        vecs[23] = '{1'b0, 5'd0, 25'd0, 32'h0,   1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h20, 1'b0, 32'h0,  5'd8};
        vecs[24] = '{1'b0, 5'd0, 25'd0, 32'h0,   1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 32'h100, 5'd4};
        vecs[25] = '{1'b0, 5'd0, 25'd0, 32'h0,   1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 32'h100, 5'd5};

        idle_inputs();
        pc_i    = 32'h10;
        reset_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_i = 1'b0;

        for (int i = 0; i < NUM_VECS; i++) begin
            apply_vec(vecs[i], i);
        end

        // Reset between clock edges: outputs clear before the next rising edge.
        @(negedge clk);
        idle_inputs();
        pc_i = 32'h10;
        #1;
        check("pre-reset taken", {31'd0, BranchTaken_o}, 32'd1);
        @(posedge clk);
        #2;
        reset_i = 1'b1;
        #1;
        check("async reset taken", {31'd0, BranchTaken_o}, 32'd0);
        check("async reset target", BTBtarget_o, 32'h0);
        check("async reset phtaddr", {27'd0, PHTreadaddress_o}, 32'd4);

        // A write presented while reset is held must be lost.
        @(negedge clk);
        BTB_we = 1'b1; BTBwriteaddress_i = 5'd4; BTBwritetag_i = 25'd0;
        BTBwritedata_i = 32'h99; BTBwritejump_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        reset_i = 1'b0;
        #1;
        check("write during reset taken", {31'd0, BranchTaken_o}, 32'd0);
        check("write during reset target", BTBtarget_o, 32'h0);

        // Counters reset to weakly not-taken: a single increment makes the prediction taken.
        @(negedge clk);
        BTB_we = 1'b1; BTBwriteaddress_i = 5'd4; BTBwritetag_i = 25'd0;
        BTBwritedata_i = 32'h44; BTBwritejump_i = 1'b0;
        PHTwe_i = 1'b1; PHTwriteaddress_i = 5'd4; PHTincrement_i = 1'b1;
        @(negedge clk);
        idle_inputs();
        #1;
        check("post-reset counter taken", {31'd0, BranchTaken_o}, 32'd1);
        check("post-reset target", BTBtarget_o, 32'h44);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
